// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_issue_ctrl
//  Description : E-stage issue/sequencing control for the multi-cycle
//                mult/div unit. Issues start/write pulses, tracks a shadow
//                busy counter, stalls D-stage MDU ops, rolls back ops whose
//                instruction is flushed in M, and flags counter/busy skew.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic [31:0]      e_rs,
    input  logic [31:0]      e_rt,
    input  logic             d_md_use,
    input  logic             m_exc,
    input  logic             mdu_busy,
    output logic             mdu_start,
    output logic             mdu_we,
    output logic             mdu_return,
    output logic [3:0]       mdu_op,
    output logic [31:0]      mdu_a,
    output logic [31:0]      mdu_b,
    output logic             stall,
    output logic [CNT_W-1:0] op_done_cnt,
    output logic             sync_err
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_mult_n   = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_n    = c_cnt_w'(DIV_CYCLES);
    localparam logic [CNT_W-1:0]   c_done_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // ISSUED: op sits in M and may still be cancelled; RUN: op retired past M.
    typedef enum logic [1:0] {
        c_st_idle   = 2'd0,
        c_st_issued = 2'd1,
        c_st_run    = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_cnt_w-1:0]   r_cnt_q,   w_cnt_d;
    logic [CNT_W-1:0]     r_done_q,  w_done_d;
    logic                 r_err_q,   w_err_d;
    logic                 r_cancel_q;

    logic w_is_md, w_is_mt, w_is_mult;
    logic w_start, w_we, w_return, w_mismatch;

    assign w_is_md   = (e_op == 4'd1) || (e_op == 4'd2) || (e_op == 4'd5) || (e_op == 4'd6);
    assign w_is_mt   = (e_op == 4'd3) || (e_op == 4'd4);
    assign w_is_mult = (e_op == 4'd1) || (e_op == 4'd5);

    // Next-state, shadow counter and completion count; pulses only from IDLE/ISSUED
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_done_d  = r_done_q;
        w_start   = 1'b0;
        w_we      = 1'b0;
        w_return  = 1'b0;
        case (r_state_q)
            c_st_idle: begin
                // An exception in M flushes the E instruction: no MDU side effect.
                if (e_valid && !m_exc) begin
                    if (w_is_md) begin
                        w_start   = 1'b1;
                        w_cnt_d   = w_is_mult ? c_mult_n : c_div_n;
                        w_state_d = c_st_issued;
                    end else if (w_is_mt) begin
                        w_we = 1'b1;
                    end
                end
            end
            c_st_issued: begin
                if (m_exc) begin
                    w_return  = 1'b1;
                    w_cnt_d   = c_cnt_zero;
                    w_state_d = c_st_idle;
                end else begin
                    w_cnt_d = r_cnt_q - c_cnt_one;
                    if (r_cnt_q <= c_cnt_one) begin
                        w_state_d = c_st_idle;
                        w_done_d  = r_done_q + c_done_one;
                    end else begin
                        w_state_d = c_st_run;
                    end
                end
            end
            c_st_run: begin
                // Past M the op has retired, so m_exc no longer cancels it.
                w_cnt_d = r_cnt_q - c_cnt_one;
                if (r_cnt_q <= c_cnt_one) begin
                    w_state_d = c_st_idle;
                    w_done_d  = r_done_q + c_done_one;
                end
            end
            default: begin
                w_state_d = c_st_idle;
                w_cnt_d   = c_cnt_zero;
            end
        endcase
    end

    // Busy skew check; the MDU may drop busy one cycle after a roll-back
    always_comb begin
        w_mismatch = ((r_state_q == c_st_idle) && mdu_busy && !r_cancel_q) ||
                     ((r_state_q != c_st_idle) && !mdu_busy);
        w_err_d    = r_err_q || w_mismatch;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= c_st_idle;
            r_cnt_q    <= c_cnt_zero;
            r_done_q   <= '0;
            r_err_q    <= 1'b0;
            r_cancel_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_done_q   <= w_done_d;
            r_err_q    <= w_err_d;
            r_cancel_q <= w_return;
        end
    end

    // Combinational outputs are forced low while reset is held
    always_comb begin
        mdu_start  = w_start  && !reset;
        mdu_we     = w_we     && !reset;
        mdu_return = w_return && !reset;
        stall      = d_md_use && (w_start || (r_state_q != c_st_idle)) && !reset;
        mdu_op     = reset ? 4'd0  : e_op;
        mdu_a      = reset ? 32'd0 : e_rs;
        mdu_b      = reset ? 32'd0 : e_rt;
    end

    assign op_done_cnt = r_done_q;
    assign sync_err    = r_err_q;

endmodule
`default_nettype wire
